// File: rtl/digital_port.sv
// Memory-mapped GPIO port: per-bit direction/output-data registers drive a tri-state pad bus,
// and the live pad levels are read back while the port is selected.

module digital_port_lane (
    input  logic clk,
    input  logic reset,
    input  logic wrDir,
    input  logic wrOut,
    input  logic dIn,
    output logic dirBit,
    output logic outBit
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dirBit <= 1'b0;
            outBit <= 1'b0;
        end else begin
            if (wrDir) dirBit <= dIn;
            if (wrOut) outBit <= dIn;
        end
    end
endmodule

module digital_port #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipSelect,
    input  logic             writeIO,
    input  logic             writeDirection,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    inout  wire  [WIDTH-1:0] IO
);
    typedef struct packed {
        logic             wrDir;
        logic             wrOut;
        logic [WIDTH-1:0] data;
    } wrReq_t;

    wrReq_t           req;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] outData;

    // Strobes are qualified by chipSelect once here so lanes stay decoder-agnostic.
    always_comb begin
        req.wrDir = chipSelect & writeDirection;
        req.wrOut = chipSelect & writeIO;
        req.data  = dataIn;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gLane
        digital_port_lane uLane (
            .clk    (clk),
            .reset  (reset),
            .wrDir  (req.wrDir),
            .wrOut  (req.wrOut),
            .dIn    (req.data[i]),
            .dirBit (direction[i]),
            .outBit (outData[i])
        );
        assign IO[i] = direction[i] ? outData[i] : 1'bz;
    end

    assign dataOut = chipSelect ? IO : '0;
endmodule

// File: tb/tb_digital_port.sv
// Bench for digital_port: table of write/read vectors with hand-derived read-back values,
// checked through an expected-value queue, plus an asynchronous mid-sequence reset.

module tb_digital_port;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         chipSelect = 1'b0;
    logic         writeIO = 1'b0;
    logic         writeDirection = 1'b0;
    logic [W-1:0] dataIn = '0;
    logic [W-1:0] dataOut;
    wire  [W-1:0] IO;

    logic [W-1:0] extVal = '0;
    logic [W-1:0] extEn = '0;
    logic [W-1:0] tbDir = '0;

    int passCnt = 0;
    int totalCnt = 0;

    typedef struct {
        string        name;
        logic         cs;
        logic         wIO;
        logic         wDir;
        logic [W-1:0] data;
        logic         readCs;
        logic [W-1:0] ext;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] expQ[$];
    string        nameQ[$];

    always #5 clk = ~clk;

    // External world drives only the pads the bench believes are inputs.
    for (genvar i = 0; i < W; i++) begin : gExt
        assign IO[i] = extEn[i] ? extVal[i] : 1'bz;
    end

    digital_port #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .chipSelect     (chipSelect),
        .writeIO        (writeIO),
        .writeDirection (writeDirection),
        .dataIn         (dataIn),
        .dataOut        (dataOut),
        .IO             (IO)
    );

    task automatic drivePads(input logic [W-1:0] ext);
        extVal = ext;
        extEn  = ~tbDir;
    endtask

    task automatic checkOne();
        logic [W-1:0] e;
        string        n;
        e = expQ.pop_front();
        n = nameQ.pop_front();
        totalCnt++;
        if (dataOut === e) passCnt++;
        else $display("FAIL %s: dataOut=%08h expected=%08h", n, dataOut, e);
    endtask

    task automatic runVec(input vec_t v);
        @(negedge clk);
        chipSelect     = v.cs;
        writeIO        = v.wIO;
        writeDirection = v.wDir;
        dataIn         = v.data;
        @(posedge clk);
        #1;
        if (v.cs && v.wDir) tbDir = v.data;
        chipSelect     = v.readCs;
        writeIO        = 1'b0;
        writeDirection = 1'b0;
        dataIn         = '0;
        drivePads(v.ext);
        expQ.push_back(v.exp);
        nameQ.push_back(v.name);
        #2;
        checkOne();
    endtask

    task automatic addVec(input string n, input logic cs, input logic wIO, input logic wDir,
                          input logic [W-1:0] d, input logic rcs, input logic [W-1:0] ext,
                          input logic [W-1:0] exp);
        vec_t v;
        v.name = n; v.cs = cs; v.wIO = wIO; v.wDir = wDir; v.data = d;
        v.readCs = rcs; v.ext = ext; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        //      name          cs wIO wDir data          rdCs ext           expected
        addVec("dirWrite",    1, 0,  1,   32'hFF00FF00, 1,   32'hFFFFFFFF, 32'h00FF00FF);
        addVec("dirExtLow",   0, 0,  0,   32'h00000000, 1,   32'h00000000, 32'h00000000);
        addVec("outWrite",    1, 1,  0,   32'hFFFFFFFF, 1,   32'h12345678, 32'hFF34FF78);
        addVec("idleHold",    1, 0,  0,   32'h00000000, 1,   32'h12345678, 32'hFF34FF78);
        addVec("csLowA",      0, 1,  1,   32'hAAAAAAAA, 1,   32'h12345678, 32'hFF34FF78);
        addVec("csLowB",      0, 1,  1,   32'hAAAAAAAA, 1,   32'h00000000, 32'hFF00FF00);
        addVec("csLowC",      0, 1,  0,   32'hAAAAAAAA, 1,   32'hFFFFFFFF, 32'hFFFFFFFF);
        addVec("readCsLow",   0, 0,  0,   32'h00000000, 0,   32'hFFFFFFFF, 32'h00000000);
        addVec("bothStrobes", 1, 1,  1,   32'h0000FFFF, 1,   32'hFFFF0000, 32'hFFFFFFFF);
        addVec("bothExtLow",  0, 0,  0,   32'h00000000, 1,   32'h00000000, 32'h0000FFFF);
        addVec("outWhileIn",  1, 1,  0,   32'h5A5A0000, 1,   32'h00000000, 32'h00000000);
        addVec("outWhileInX", 0, 0,  0,   32'h00000000, 1,   32'hFFFF0000, 32'hFFFF0000);
        addVec("dirRevealOut",1, 0,  1,   32'hFFFFFFFF, 1,   32'h00000000, 32'h5A5A0000);

        // Reset state: pads undriven, so the external level reads straight through.
        chipSelect = 1'b1;
        drivePads(32'hA5A5A5A5);
        #3;
        expQ.push_back(32'hA5A5A5A5); nameQ.push_back("resetPadsZ");
        checkOne();
        drivePads(32'h00000000);
        #1;
        expQ.push_back(32'h00000000); nameQ.push_back("resetPadsZ0");
        checkOne();
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[k]) runVec(vecs[k]);

        // Asynchronous reset between edges while all pads drive 5A5A0000.
        @(negedge clk);
        #1;
        reset = 1'b0;
        tbDir = '0;
        drivePads(32'h00000000);
        #1;
        expQ.push_back(32'h00000000); nameQ.push_back("asyncRstTriZ");
        checkOne();
        drivePads(32'h3C3C3C3C);
        #1;
        expQ.push_back(32'h3C3C3C3C); nameQ.push_back("asyncRstExt");
        checkOne();
        @(negedge clk);
        reset = 1'b1;

        // After release, enabling all outputs must expose a cleared outData.
        begin
            vec_t v;
            v.name = "postRstOut"; v.cs = 1; v.wIO = 0; v.wDir = 1; v.data = 32'hFFFFFFFF;
            v.readCs = 1; v.ext = 32'hFFFFFFFF; v.exp = 32'h00000000;
            runVec(v);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish, passed=%0d total=%0d", passCnt, totalCnt);
        $fatal(1);
    end
endmodule
